vga_frame_writer: RTL



---
 rtl/vga_frame_writer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_writer.sv
// VGA frame writer: Avalon-MM slave that buffers CPU-pushed RGB pixels in a
// small FIFO and streams them out with VGA timing, starting on a frame boundary.
module vga_frame_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        HSYNC,
  output logic        VSYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {DISABLED, WAIT_FRAME, STREAMING} state_t;

  state_t          state;
  logic            enable;
  logic            underflow;
  logic            overflow;
  logic [31:0]     frame_cnt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [23:0]     mem [FIFO_DEPTH];

  logic h_last, v_last, at_origin, active, empty, full;
  logic wr_pix, wr_ctl, flush, stream_now, pop, starve, push_ok, push_drop;
  logic unused_bits;

  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);

  assign wr_pix = chipselect && write && (address == 8'd0);
  assign wr_ctl = chipselect && write && (address == 8'd1);
  assign flush  = wr_ctl && writedata[1];

  // A frame armed in WAIT_FRAME must already emit its first pixel at (0,0),
  // the same cycle the FSM moves to STREAMING.
  assign stream_now = (state == STREAMING) || ((state == WAIT_FRAME) && at_origin);
  assign pop        = stream_now && active && !empty && !flush;
  assign starve     = stream_now && active && empty && !flush;
  assign push_ok    = wr_pix && (!full || pop);
  assign push_drop  = wr_pix && full && !pop;

  // Low control bits beyond enable/flush carry no meaning for this block.
  assign unused_bits = ^writedata[7:2];

  // Free-running raster counters, independent of the streaming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Streaming FSM; a disable write wins over any pending transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DISABLED;
      enable <= 1'b0;
    end else begin
      if (wr_ctl) enable <= writedata[0];
      if (wr_ctl && !writedata[0]) begin
        state <= DISABLED;
      end else begin
        case (state)
          DISABLED:   if (wr_ctl) state <= WAIT_FRAME;
          WAIT_FRAME: if (at_origin) state <= STREAMING;
          STREAMING:  state <= STREAMING;
          default:    state <= DISABLED;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; flush resets them outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  // Pixel storage holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata[31:8];
  end

  // Sticky error flags, cleared together by reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (starve)    underflow <= 1'b1;
      if (push_drop) overflow  <= 1'b1;
    end
  end

  // Count completed frames while streaming.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if ((state == STREAMING) && h_last && v_last) begin
      frame_cnt <= frame_cnt + 32'd1;
    end
  end

  // Registered VGA outputs, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      VGA_R <= 8'd0;
      VGA_G <= 8'd0;
      VGA_B <= 8'd0;
      HSYNC <= 1'b1;
      VSYNC <= 1'b1;
    end else begin
      HSYNC <= !((h_cnt >= H_SYNC_LO) && (h_cnt < H_SYNC_HI));
      VSYNC <= !((v_cnt >= V_SYNC_LO) && (v_cnt < V_SYNC_HI));
      if (pop) begin
        VGA_R <= mem[rd_ptr][23:16];
        VGA_G <= mem[rd_ptr][15:8];
        VGA_B <= mem[rd_ptr][7:0];
      end else begin
        VGA_R <= 8'd0;
        VGA_G <= 8'd0;
        VGA_B <= 8'd0;
      end
    end
  end

  // Combinational register read; zero when not addressed.
  always_comb begin
    readdata = 32'd0;
    if (chipselect && read) begin
      case (address)
        8'd0: readdata = {16'd0, 8'(count), 2'b00, (state == STREAMING),
                          overflow, underflow, empty, full, enable};
        8'd1: readdata = frame_cnt;
        default: readdata = 32'd0;
      endcase
    end
  end

endmodule
